// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered ID/EX stage feeding the ALU.
//   - Decodes opcode/funct3/funct7[5] into a 4-bit ALU operation.
//   - Resolves rs1/rs2 forwarding (EX/MEM over MEM/WB over register file).
//   - Selects ALU operands and holds results in an output register plus one skid entry.
// Ports:
//   clk, rst_n (async active-low), flush (sync kill of held and incoming entries)
//   in_*      : upstream decoded instruction with in_valid/in_ready handshake
//   fwd_ex_*  : EX/MEM forwarding source;  fwd_wb_* : MEM/WB forwarding source
//   out_valid/out_ready handshake, alu_op, alu_in_a, alu_in_b, out_rd_addr,
//   out_rs2_data, out_pc to the ALU / downstream.
// ALU op encoding: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 invalid=15.
module alu_issue_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7_5,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic                  fwd_ex_valid,
  input  logic [REG_ADDR_W-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0]       fwd_ex_data,
  input  logic                  fwd_wb_valid,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]       fwd_wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            alu_op,
  output logic [XLEN-1:0]       alu_in_a,
  output logic [XLEN-1:0]       alu_in_b,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic [XLEN-1:0]       out_rs2_data,
  output logic [XLEN-1:0]       out_pc
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpSll  = 4'd2;
  localparam logic [3:0] OpSlt  = 4'd3;
  localparam logic [3:0] OpSltu = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpOr   = 4'd8;
  localparam logic [3:0] OpAnd  = 4'd9;
  localparam logic [3:0] OpInv  = 4'd15;

  typedef struct packed {
    logic [3:0]            op;
    logic [XLEN-1:0]       a;
    logic [XLEN-1:0]       b;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rs2;
    logic [XLEN-1:0]       pc;
  } entry_t;

  localparam entry_t EntryRst = '{op: OpInv, a: '0, b: '0, rd: '0, rs2: '0, pc: '0};

  entry_t out_q, out_d, skid_q, skid_d, new_entry;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  // Holds in_ready low until the first edge after reset release.
  logic   live_q, live_d;

  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic [3:0]      reg_op;
  logic            accept;

  assign in_ready = live_q & ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;

  // Forwarding: x0 never forwards, EX/MEM has priority over MEM/WB.
  always_comb begin
    rs1_fwd = in_rs1_data;
    if (in_rs1_addr != '0 && fwd_ex_valid && fwd_ex_rd == in_rs1_addr) begin
      rs1_fwd = fwd_ex_data;
    end else if (in_rs1_addr != '0 && fwd_wb_valid && fwd_wb_rd == in_rs1_addr) begin
      rs1_fwd = fwd_wb_data;
    end
    rs2_fwd = in_rs2_data;
    if (in_rs2_addr != '0 && fwd_ex_valid && fwd_ex_rd == in_rs2_addr) begin
      rs2_fwd = fwd_ex_data;
    end else if (in_rs2_addr != '0 && fwd_wb_valid && fwd_wb_rd == in_rs2_addr) begin
      rs2_fwd = fwd_wb_data;
    end
  end

  // funct3 to ALU op for OP/OP-IMM, with funct7[5] applied to ADD and shifts.
  always_comb begin
    reg_op = OpAdd;
    unique case (in_funct3)
      3'b000: reg_op = in_funct7_5 ? OpSub : OpAdd;
      3'b001: reg_op = OpSll;
      3'b010: reg_op = OpSlt;
      3'b011: reg_op = OpSltu;
      3'b100: reg_op = OpXor;
      3'b101: reg_op = in_funct7_5 ? OpSra : OpSrl;
      3'b110: reg_op = OpOr;
      3'b111: reg_op = OpAnd;
      default: reg_op = OpAdd;
    endcase
  end

  always_comb begin
    new_entry     = EntryRst;
    new_entry.rd  = in_rd_addr;
    new_entry.rs2 = rs2_fwd;
    new_entry.pc  = in_pc;
    unique case (in_opcode)
      7'b0110011: begin
        new_entry.op = reg_op;
        new_entry.a  = rs1_fwd;
        new_entry.b  = rs2_fwd;
      end
      7'b0010011: begin
        // funct7[5] only distinguishes SRAI; ADDI never becomes SUB.
        new_entry.op = (in_funct3 == 3'b000) ? OpAdd : reg_op;
        new_entry.a  = rs1_fwd;
        new_entry.b  = in_imm;
      end
      7'b0110111: begin
        new_entry.op = OpAdd;
        new_entry.b  = in_imm;
      end
      7'b0010111: begin
        new_entry.op = OpAdd;
        new_entry.a  = in_pc;
        new_entry.b  = in_imm;
      end
      7'b0000011, 7'b0100011: begin
        new_entry.op = OpAdd;
        new_entry.a  = rs1_fwd;
        new_entry.b  = in_imm;
      end
      7'b1100011: begin
        new_entry.a = rs1_fwd;
        new_entry.b = rs2_fwd;
        unique case (in_funct3[2:1])
          2'b00:   new_entry.op = OpSub;
          2'b10:   new_entry.op = OpSlt;
          2'b11:   new_entry.op = OpSltu;
          default: new_entry.op = OpInv;
        endcase
      end
      7'b1101111, 7'b1100111: begin
        new_entry.op = OpAdd;
        new_entry.a  = in_pc;
        new_entry.b  = XLEN'(4);
      end
      default: ;
    endcase
  end

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    live_d       = 1'b1;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Skid full implies output full and in_ready low, so no accept here.
      if (out_ready) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= EntryRst;
      skid_q       <= EntryRst;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      live_q       <= live_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign alu_op       = out_q.op;
  assign alu_in_a     = out_q.a;
  assign alu_in_b     = out_q.b;
  assign out_rd_addr  = out_q.rd;
  assign out_rs2_data = out_q.rs2;
  assign out_pc       = out_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [31:0] in_pc, in_imm, in_rs1_data, in_rs2_data;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        fwd_ex_valid, fwd_wb_valid;
  logic [4:0]  fwd_ex_rd, fwd_wb_rd;
  logic [31:0] fwd_ex_data, fwd_wb_data;
  logic        out_valid, out_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_in_a, alu_in_b, out_rs2_data, out_pc;
  logic [4:0]  out_rd_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .alu_in_a(alu_in_a),
    .alu_in_b(alu_in_b), .out_rd_addr(out_rd_addr), .out_rs2_data(out_rs2_data),
    .out_pc(out_pc)
  );

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f75;
    logic [31:0] pc, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [31:0] rs1d, rs2d;
    logic        exv;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic [3:0]  e_op;
    logic [31:0] e_a, e_b, e_rs2;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; in_opcode = 7'b0110011; in_funct3 = 0; in_funct7_5 = 0;
    in_pc = 0; in_imm = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; fwd_ex_valid = 0; fwd_ex_rd = 0; fwd_ex_data = 0;
    fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1; in_opcode = v.opc; in_funct3 = v.f3; in_funct7_5 = v.f75; in_pc = v.pc;
    in_imm = v.imm; in_rs1_addr = v.rs1a; in_rs2_addr = v.rs2a; in_rd_addr = v.rd;
    in_rs1_data = v.rs1d; in_rs2_data = v.rs2d; fwd_ex_valid = v.exv; fwd_ex_rd = v.exrd;
    fwd_ex_data = v.exd; fwd_wb_valid = v.wbv; fwd_wb_rd = v.wbrd; fwd_wb_data = v.wbd;
  endtask

  task automatic add_vec(input string n, input logic [6:0] opc, input logic [2:0] f3,
                         input logic f75, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [4:0] rs1a, input logic [4:0] rs2a,
                         input logic [31:0] rs1d, input logic [31:0] rs2d,
                         input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
                         input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                         input logic [3:0] e_op, input logic [31:0] e_a,
                         input logic [31:0] e_b, input logic [31:0] e_rs2);
    vec_t v;
    v.name = n; v.opc = opc; v.f3 = f3; v.f75 = f75; v.pc = pc; v.imm = imm;
    v.rs1a = rs1a; v.rs2a = rs2a; v.rd = 5'(vecs.size() + 1); v.rs1d = rs1d; v.rs2d = rs2d;
    v.exv = exv; v.exrd = exrd; v.exd = exd; v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
    v.e_op = e_op; v.e_a = e_a; v.e_b = e_b; v.e_rs2 = e_rs2;
    vecs.push_back(v);
  endtask

  task automatic push_pc(input logic [31:0] pc);
    in_valid = 1; in_opcode = 7'b1101111; in_pc = pc;
  endtask

  initial begin
    int got[$];
    int seen_flushed;
    // Expected op codes: ADD=0 SUB=1 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 invalid=15.
    add_vec("op_sub", 7'b0110011, 3'b000, 1, 32'h40, 0, 1, 2, 5, 7,
            0, 0, 0, 0, 0, 0, 4'd1, 5, 7, 7);
    add_vec("fwd_ex_prio", 7'b0110011, 3'b000, 0, 32'h44, 0, 3, 4, 1, 2,
            1, 3, 32'hAAAA, 1, 3, 32'hBBBB, 4'd0, 32'hAAAA, 2, 2);
    add_vec("fwd_x0", 7'b0110011, 3'b000, 0, 32'h48, 0, 0, 0, 32'h1234, 32'h55,
            1, 0, 32'hAAAA, 1, 0, 32'hBBBB, 4'd0, 32'h1234, 32'h55, 32'h55);
    add_vec("fwd_wb_only", 7'b0110011, 3'b101, 0, 32'h4c, 0, 9, 6, 32'h10, 32'h20,
            1, 7, 32'hAAAA, 1, 6, 32'hCCCC, 4'd6, 32'h10, 32'hCCCC, 32'hCCCC);
    add_vec("auipc", 7'b0010111, 3'b000, 0, 32'h100, 32'h1000, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 4'd0, 32'h100, 32'h1000, 0);
    add_vec("srai", 7'b0010011, 3'b101, 1, 32'h50, 3, 1, 0, 32'h80000000, 0,
            0, 0, 0, 0, 0, 0, 4'd7, 32'h80000000, 3, 0);
    add_vec("addi_f7", 7'b0010011, 3'b000, 1, 32'h54, 32'hFFFFFFFF, 1, 0, 32'h9, 0,
            0, 0, 0, 0, 0, 0, 4'd0, 32'h9, 32'hFFFFFFFF, 0);
    add_vec("xori", 7'b0010011, 3'b100, 0, 32'h58, 32'hF0, 1, 0, 32'h3, 0,
            0, 0, 0, 0, 0, 0, 4'd5, 32'h3, 32'hF0, 0);
    add_vec("bad_opc", 7'b0001111, 3'b000, 0, 32'h5c, 32'h77, 1, 2, 32'h11, 32'h22,
            0, 0, 0, 0, 0, 0, 4'd15, 0, 0, 32'h22);
    add_vec("lui", 7'b0110111, 3'b000, 0, 32'h60, 32'hABCDE000, 1, 0, 32'h99, 0,
            0, 0, 0, 0, 0, 0, 4'd0, 0, 32'hABCDE000, 0);
    add_vec("load", 7'b0000011, 3'b010, 0, 32'h64, 32'h8, 1, 0, 32'h1000, 0,
            0, 0, 0, 0, 0, 0, 4'd0, 32'h1000, 32'h8, 0);
    add_vec("bltu", 7'b1100011, 3'b110, 0, 32'h68, 0, 1, 2, 32'h3, 32'h4,
            0, 0, 0, 0, 0, 0, 4'd4, 32'h3, 32'h4, 32'h4);
    add_vec("beq", 7'b1100011, 3'b001, 0, 32'h6c, 0, 1, 2, 32'h3, 32'h4,
            0, 0, 0, 0, 0, 0, 4'd1, 32'h3, 32'h4, 32'h4);
    add_vec("br_f3_010", 7'b1100011, 3'b010, 0, 32'h70, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 4'd15, 0, 0, 0);
    add_vec("jal", 7'b1101111, 3'b000, 0, 32'h200, 32'h40, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 4'd0, 32'h200, 4, 0);

    idle_inputs();
    out_ready = 1;
    rst_n = 0;
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_alu_op", 32'(alu_op), 32'hF);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_pc", out_pc, 0);
    rst_n = 1;
    #1;
    check("rst_rel_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("in_ready_after_rel", 32'(in_ready), 1);

    // Back-to-back vectors, one accepted per cycle.
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      check({vecs[i].name, "_valid"}, 32'(out_valid), 1);
      check({vecs[i].name, "_op"}, 32'(alu_op), 32'(vecs[i].e_op));
      check({vecs[i].name, "_a"}, alu_in_a, vecs[i].e_a);
      check({vecs[i].name, "_b"}, alu_in_b, vecs[i].e_b);
      check({vecs[i].name, "_rs2"}, out_rs2_data, vecs[i].e_rs2);
      check({vecs[i].name, "_pc"}, out_pc, vecs[i].pc);
      check({vecs[i].name, "_rd"}, 32'(out_rd_addr), 32'(vecs[i].rd));
    end
    idle_inputs();
    @(posedge clk); #1;
    check("drain_valid", 32'(out_valid), 0);

    // Backpressure: three entries with out_ready low, then release.
    out_ready = 0;
    push_pc(32'h0);
    @(posedge clk); #1;
    push_pc(32'h4);
    @(posedge clk); #1;
    check("bp_in_ready_full", 32'(in_ready), 0);
    push_pc(32'h8);
    @(posedge clk); #1;
    check("bp_hold_pc", out_pc, 0);
    check("bp_hold_valid", 32'(out_valid), 1);
    check("bp_in_ready_3rd", 32'(in_ready), 0);
    out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      logic consumed, accepted;
      logic [31:0] cpc;
      consumed = out_valid && out_ready;
      cpc = out_pc;
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (consumed) got.push_back(int'(cpc));
      if (accepted) in_valid = 0;
    end
    check("bp_count", 32'(got.size()), 3);
    if (got.size() == 3) begin
      check("bp_pc0", 32'(got[0]), 32'h0);
      check("bp_pc1", 32'(got[1]), 32'h4);
      check("bp_pc2", 32'(got[2]), 32'h8);
    end

    // Flush with output and skid full plus an incoming entry.
    out_ready = 0;
    push_pc(32'h10);
    @(posedge clk); #1;
    push_pc(32'h14);
    @(posedge clk); #1;
    check("fl_pre_valid", 32'(out_valid), 1);
    push_pc(32'h18);
    flush = 1;
    out_ready = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    check("fl_out_valid", 32'(out_valid), 0);
    check("fl_in_ready", 32'(in_ready), 1);
    seen_flushed = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen_flushed++;
      @(posedge clk); #1;
    end
    check("fl_no_leak", 32'(seen_flushed), 0);

    // Async reset while an entry is presented.
    out_ready = 0;
    push_pc(32'h30);
    @(posedge clk); #1;
    in_valid = 0;
    check("ar_pre_valid", 32'(out_valid), 1);
    #2 rst_n = 0;
    #1;
    check("ar_out_valid", 32'(out_valid), 0);
    check("ar_alu_op", 32'(alu_op), 32'hF);
    check("ar_out_pc", out_pc, 0);
    check("ar_in_ready", 32'(in_ready), 0);
    #10 rst_n = 1;
    @(posedge clk); #1;
    check("ar_post_valid", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
